// File: rtl/ase_emul_pcie_ss_axis_demux_pkg.sv
// Shared definitions for the PCIe SS AXI-S demultiplexer: FSM state encoding,
// drop counter width and a saturating increment helper.
package ase_emul_pcie_ss_axis_demux_pkg;

  localparam int unsigned DROP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    StSop  = 2'd0,
    StFwd  = 2'd1,
    StDrop = 2'd2
  } demux_state_e;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + DROP_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ofs_pcie_ss_cfg_pkg.sv
// PCIe subsystem configuration constants shared by the AXI-S emulation blocks.
// Provides the default data and vendor-user widths for pcie_ss_axis_if.
package ofs_pcie_ss_cfg_pkg;

  localparam int unsigned TDATA_WIDTH = 512;
  localparam int unsigned TUSER_WIDTH = 10;

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-S stream bundle used by the PCIe SS emulation.
//   sink   : consumer view (valid/data/keep/last/user in, ready out)
//   source : producer view (valid/data/keep/last/user out, ready in)
interface pcie_ss_axis_if #(
  parameter int unsigned DATA_W = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
  parameter int unsigned USER_W = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH
);

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic [USER_W-1:0]     tuser_vendor;

  modport sink (
    input  tvalid, tlast, tdata, tkeep, tuser_vendor,
    output tready
  );

  modport source (
    output tvalid, tlast, tdata, tkeep, tuser_vendor,
    input  tready
  );

endinterface

// File: rtl/ase_emul_pcie_ss_axis_demux_out_reg.sv
// One-beat registered output stage for a single demux channel.
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   load                   capture ld_* this cycle
//   ld_data/keep/last/user beat to capture
//   tready                 downstream ready
//   tvalid/tdata/tkeep/tlast/tuser  registered stream outputs
//   can_load               stage is empty or draining this cycle
module ase_emul_pcie_ss_axis_demux_out_reg
  import ase_emul_pcie_ss_axis_demux_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [TDATA_WIDTH-1:0]   ld_data,
  input  logic [TDATA_WIDTH/8-1:0] ld_keep,
  input  logic                     ld_last,
  input  logic [TUSER_WIDTH-1:0]   ld_user,
  input  logic                     tready,
  output logic                     tvalid,
  output logic [TDATA_WIDTH-1:0]   tdata,
  output logic [TDATA_WIDTH/8-1:0] tkeep,
  output logic                     tlast,
  output logic [TUSER_WIDTH-1:0]   tuser,
  output logic                     can_load
);

  logic valid_q;

  assign can_load = ~valid_q | tready;
  assign tvalid   = valid_q;

  // A load while the current beat drains keeps valid high with new contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (tready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      tdata <= ld_data;
      tkeep <= ld_keep;
      tlast <= ld_last;
      tuser <= ld_user;
    end
  end

endmodule

// File: rtl/ase_emul_pcie_ss_axis_demux.sv
// Routes packets from one AXI-S sink to one of NUM_CH sources. The route is
// taken from tdata[ROUTE_LSB +: SEL_WIDTH] of each packet's first beat; packets
// whose route is not a valid channel are consumed and counted as drops.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   sink           single inbound stream
//   source[NUM_CH] outbound streams, one registered stage each
//   err_route      one-cycle pulse per dropped packet
//   drop_cnt       saturating dropped-packet count
module ase_emul_pcie_ss_axis_demux
  import ase_emul_pcie_ss_axis_demux_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned TDATA_WIDTH = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
  parameter int unsigned TUSER_WIDTH = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH,
  parameter int unsigned ROUTE_LSB   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pcie_ss_axis_if.sink              sink,
  pcie_ss_axis_if.source            source [NUM_CH],
  output logic                      err_route,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int unsigned SEL_WIDTH  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int unsigned KEEP_WIDTH = TDATA_WIDTH / 8;

  // Input holding register
  logic                   in_valid_q;
  logic [TDATA_WIDTH-1:0] in_data_q;
  logic [KEEP_WIDTH-1:0]  in_keep_q;
  logic                   in_last_q;
  logic [TUSER_WIDTH-1:0] in_user_q;
  logic                   in_done;
  logic                   sink_ready;
  logic                   sink_fire;

  assign sink_ready  = ~in_valid_q | in_done;
  assign sink.tready = sink_ready;
  assign sink_fire   = sink.tvalid & sink_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
    end else if (sink_fire) begin
      in_valid_q <= 1'b1;
    end else if (in_done) begin
      in_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sink_fire) begin
      in_data_q <= sink.tdata;
      in_keep_q <= sink.tkeep;
      in_last_q <= sink.tlast;
      in_user_q <= sink.tuser_vendor;
    end
  end

  // Routing decode and per-beat handshake
  demux_state_e          state_q;
  logic [SEL_WIDTH-1:0]  target_q;
  logic                  err_route_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  logic [SEL_WIDTH-1:0]  route;
  logic                  route_ok;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  sel_ready;
  logic                  fwd;
  logic [NUM_CH-1:0]     out_ready;
  logic [NUM_CH-1:0]     load;

  assign route    = in_data_q[ROUTE_LSB +: SEL_WIDTH];
  assign route_ok = 32'(route) < NUM_CH;
  // The header beat steers by its own route field; body beats by the latched target.
  assign sel      = (state_q == StFwd) ? target_q : route;

  always_comb begin
    sel_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel == SEL_WIDTH'(c)) begin
        sel_ready = out_ready[c];
      end
    end
  end

  always_comb begin
    fwd     = 1'b0;
    in_done = 1'b0;
    unique case (state_q)
      StSop: begin
        if (route_ok) begin
          fwd     = in_valid_q;
          in_done = in_valid_q & sel_ready;
        end else begin
          in_done = in_valid_q;
        end
      end
      StFwd: begin
        fwd     = in_valid_q;
        in_done = in_valid_q & sel_ready;
      end
      StDrop: begin
        in_done = in_valid_q;
      end
      default: begin
        in_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StSop;
      target_q    <= '0;
      err_route_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      err_route_q <= 1'b0;
      unique case (state_q)
        StSop: begin
          if (in_valid_q) begin
            if (route_ok) begin
              if (in_done) begin
                target_q <= route;
                if (!in_last_q) begin
                  state_q <= StFwd;
                end
              end
            end else begin
              err_route_q <= 1'b1;
              drop_cnt_q  <= sat_inc(drop_cnt_q);
              if (!in_last_q) begin
                state_q <= StDrop;
              end
            end
          end
        end
        StFwd, StDrop: begin
          if (in_done && in_last_q) begin
            state_q <= StSop;
          end
        end
        default: begin
          state_q <= StSop;
        end
      endcase
    end
  end

  assign err_route = err_route_q;
  assign drop_cnt  = drop_cnt_q;

  // Per-channel output stages
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                   ch_valid;
    logic [TDATA_WIDTH-1:0] ch_data;
    logic [KEEP_WIDTH-1:0]  ch_keep;
    logic                   ch_last;
    logic [TUSER_WIDTH-1:0] ch_user;

    assign load[c] = fwd & in_done & (sel == SEL_WIDTH'(c));

    ase_emul_pcie_ss_axis_demux_out_reg #(
      .TDATA_WIDTH (TDATA_WIDTH),
      .TUSER_WIDTH (TUSER_WIDTH)
    ) u_out_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[c]),
      .ld_data  (in_data_q),
      .ld_keep  (in_keep_q),
      .ld_last  (in_last_q),
      .ld_user  (in_user_q),
      .tready   (source[c].tready),
      .tvalid   (ch_valid),
      .tdata    (ch_data),
      .tkeep    (ch_keep),
      .tlast    (ch_last),
      .tuser    (ch_user),
      .can_load (out_ready[c])
    );

    assign source[c].tvalid       = ch_valid;
    assign source[c].tdata        = ch_data;
    assign source[c].tkeep        = ch_keep;
    assign source[c].tlast        = ch_last;
    assign source[c].tuser_vendor = ch_user;
  end

endmodule
